// File: rtl/hd63701_intc.sv
// hd63701_intc: HD63701 interrupt arbiter/vector sequencer; define HD63701_INTC_NMI_FILTER_EN for a 3-tick NMI glitch filter
module hd63701_intc (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clkren,
  input  logic       NMI_n,
  input  logic       IRQ1_n,
  input  logic       ICF,
  input  logic       OCF,
  input  logic       TOF,
  input  logic       EICI,
  input  logic       EOCI,
  input  logic       ETOI,
  input  logic       SCI_REQ,
  input  logic       ACK,
  input  logic [7:0] ACKV,
  output logic       NMI,
  output logic       IRQ,
  output logic       IRQ2_TIM,
  output logic       IRQ2_SCI,
  output logic [7:0] VEC
);
  typedef enum logic [1:0] {IDLE, HOLD, SVC} state_t;
  state_t state, state_nx;
  logic [7:0] vec_nx, best;
  logic nmi_s1, nmi_s2, irq_s1, irq_s2, nmi_pend, nmi_edge, ack_hit, hold;
  logic [1:0] warm;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      {nmi_s1, nmi_s2, irq_s1, irq_s2} <= '1;
      warm <= '0;
    end else if (clkren) begin
      nmi_s1 <= NMI_n;
      nmi_s2 <= nmi_s1;
      irq_s1 <= IRQ1_n;
      irq_s2 <= irq_s1;
      warm   <= {warm[0], 1'b1};
    end
  // warm marks synchroniser outputs that reflect real pin samples, so a pin held low through reset is never seen as falling
`ifdef HD63701_INTC_NMI_FILTER_EN
  logic [1:0] low_cnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) low_cnt <= 2'd3;
    else if (clkren) low_cnt <= (nmi_s2 & warm[1]) ? 2'd0 : (low_cnt == 2'd3 ? low_cnt : low_cnt + 2'd1);
  assign nmi_edge = ~nmi_s2 & (low_cnt == 2'd2);
`else
  logic nmi_prev;
  always_ff @(posedge CLK or posedge RST)
    if (RST) nmi_prev <= 1'b0;
    else if (clkren) nmi_prev <= nmi_s2 & warm[1];
  assign nmi_edge = nmi_prev & ~nmi_s2;
`endif
  always_comb
    best = (nmi_pend | nmi_edge) ? 8'hFC :
           ~irq_s2              ? 8'hF8 :
           (ICF & EICI)         ? 8'hF6 :
           (OCF & EOCI)         ? 8'hF4 :
           (TOF & ETOI)         ? 8'hF2 :
           SCI_REQ              ? 8'hF0 : 8'h00;
  assign ack_hit = (state == HOLD) & ACK & (ACKV == VEC);
  always_comb begin
    state_nx = IDLE;
    vec_nx   = 8'h00;
    case (state)
      IDLE: begin
        state_nx = (best != 8'h00) ? HOLD : IDLE;
        vec_nx   = best;
      end
      HOLD: begin
        state_nx = ack_hit ? SVC : ((best != 8'h00) ? HOLD : IDLE);
        vec_nx   = ack_hit ? VEC : best;
      end
      default: begin
        state_nx = IDLE;
        vec_nx   = 8'h00;
      end
    endcase
  end
  // a fresh NMI edge outranks the acknowledge that would clear the latch
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= IDLE;
      VEC      <= 8'h00;
      nmi_pend <= 1'b0;
    end else if (clkren) begin
      state    <= state_nx;
      VEC      <= vec_nx;
      nmi_pend <= nmi_edge | (nmi_pend & ~(ack_hit & (ACKV == 8'hFC)));
    end
  assign hold     = (state == HOLD);
  assign NMI      = hold & (VEC == 8'hFC);
  assign IRQ      = hold & (VEC == 8'hF8);
  assign IRQ2_TIM = hold & ((VEC == 8'hF6) | (VEC == 8'hF4) | (VEC == 8'hF2));
  assign IRQ2_SCI = hold & (VEC == 8'hF0);
endmodule

// File: tb/tb_hd63701_intc.sv
// tb_hd63701_intc: vector table, corner sequences and randomized run against a pin-history reference model
module tb_hd63701_intc;
  logic clk = 1'b0, rst = 1'b1, clkren = 1'b1;
  logic nmi_n = 1'b1, irq1_n = 1'b1, icf = 1'b0, ocf = 1'b0, tof = 1'b0;
  logic eici = 1'b0, eoci = 1'b0, etoi = 1'b0, sci = 1'b0, ack = 1'b0;
  logic [7:0] ackv = 8'h00;
  logic nmi, irq, irq2_tim, irq2_sci;
  logic [7:0] vec;
  int n_tests = 0, n_fail = 0;
`ifdef HD63701_INTC_NMI_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT = 5;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT = 3;
`endif
  localparam logic [7:0] MV [6] = '{8'hFC, 8'hF8, 8'hF6, 8'hF4, 8'hF2, 8'hF0};

  hd63701_intc dut (
    .CLK(clk), .RST(rst), .clkren(clkren), .NMI_n(nmi_n), .IRQ1_n(irq1_n),
    .ICF(icf), .OCF(ocf), .TOF(tof), .EICI(eici), .EOCI(eoci), .ETOI(etoi),
    .SCI_REQ(sci), .ACK(ack), .ACKV(ackv),
    .NMI(nmi), .IRQ(irq), .IRQ2_TIM(irq2_tim), .IRQ2_SCI(irq2_sci), .VEC(vec)
  );

  always #5 clk = ~clk;

  // reference model: pin histories indexed by tick number since reset
  bit nq[$], iq[$];
  int t;
  bit m_pend;
  int m_phase;
  logic [7:0] m_vec;

  function automatic void model_reset();
    nq.delete();
    iq.delete();
    t = 0;
    m_pend = 0;
    m_phase = 0;
    m_vec = 8'h00;
  endfunction

  function automatic void model_step();
    bit act [6];
    bit edge_n, hit;
    logic [7:0] best;
    edge_n = 0;
`ifdef HD63701_INTC_NMI_FILTER_EN
    if (t >= 5) edge_n = !nq[t-2] && !nq[t-3] && !nq[t-4] && nq[t-5];
`else
    if (t >= 3) edge_n = !nq[t-2] && nq[t-3];
`endif
    act[0] = m_pend || edge_n;
    act[1] = (t >= 2) && !iq[t-2];
    act[2] = icf && eici;
    act[3] = ocf && eoci;
    act[4] = tof && etoi;
    act[5] = sci;
    best = 8'h00;
    for (int i = 5; i >= 0; i--) if (act[i]) best = MV[i];
    hit = (m_phase == 1) && ack && (ackv == m_vec);
    m_pend = edge_n || (m_pend && !(hit && ackv == 8'hFC));
    if (m_phase == 0) begin
      m_vec = best;
      m_phase = (best != 8'h00) ? 1 : 0;
    end else if (m_phase == 1) begin
      if (hit) m_phase = 2;
      else begin
        m_vec = best;
        m_phase = (best != 8'h00) ? 1 : 0;
      end
    end else begin
      m_phase = 0;
      m_vec = 8'h00;
    end
    nq.push_back(nmi_n);
    iq.push_back(irq1_n);
    t++;
  endfunction

  function automatic logic [11:0] model_exp();
    bit h;
    h = (m_phase == 1);
    return {h && m_vec == 8'hFC, h && m_vec == 8'hF8,
            h && (m_vec == 8'hF6 || m_vec == 8'hF4 || m_vec == 8'hF2),
            h && m_vec == 8'hF0, m_vec};
  endfunction

  function automatic void check(string name, logic [11:0] exp);
    logic [11:0] got;
    got = {nmi, irq, irq2_tim, irq2_sci, vec};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (nmi,irq,tim,sci,vec)", name, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (clkren) model_step();
    #1;
    check("model", model_exp());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("reset", 12'h000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    {irq1_n, nmi_n, icf, ocf, tof, eici, eoci, etoi, sci, ack} = 10'b1100000000;
    ackv = 8'h00;
    clkren = 1'b1;
  endtask

  // in = {irq1_n, nmi_n, icf, ocf, tof, eici, eoci, etoi, sci, ack}; exp = {nmi, irq, tim, sci, vec}
  typedef struct {
    logic [9:0]  in;
    logic [7:0]  ackv;
    int          ticks;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [23];

  initial begin
    tbl[0]  = '{10'b1100000000, 8'h00, 4, 12'h000};
    tbl[1]  = '{10'b0100000000, 8'h00, 2, 12'h000};
    tbl[2]  = '{10'b0100000000, 8'h00, 1, 12'h4F8};
    tbl[3]  = '{10'b0100000001, 8'hF8, 1, 12'h0F8};
    tbl[4]  = '{10'b0100000000, 8'h00, 1, 12'h000};
    tbl[5]  = '{10'b0100000000, 8'h00, 1, 12'h4F8};
    tbl[6]  = '{10'b0100000001, 8'hF4, 1, 12'h4F8};
    tbl[7]  = '{10'b1101001000, 8'h00, 3, 12'h2F4};
    tbl[8]  = '{10'b1001001000, 8'h00, 2, 12'h2F4};
    tbl[9]  = '{10'b1001001000, 8'h00, 1, FILT ? 12'h2F4 : 12'h8FC};
    tbl[10] = '{10'b1101001000, 8'h00, 1, FILT ? 12'h2F4 : 12'h8FC};
    tbl[11] = '{10'b1101001001, 8'hFC, 1, FILT ? 12'h2F4 : 12'h0FC};
    tbl[12] = '{10'b1101001000, 8'h00, 1, FILT ? 12'h2F4 : 12'h000};
    tbl[13] = '{10'b1101001000, 8'h00, 1, 12'h2F4};
    tbl[14] = '{10'b1100100010, 8'h00, 1, 12'h1F0};
    tbl[15] = '{10'b1100100110, 8'h00, 1, 12'h2F2};
    tbl[16] = '{10'b1110110110, 8'h00, 1, 12'h2F6};
    tbl[17] = '{10'b1100000000, 8'h00, 1, 12'h000};
    tbl[18] = '{10'b1000000000, 8'h00, 1, 12'h000};
    tbl[19] = '{10'b1100000000, 8'h00, 1, 12'h000};
    tbl[20] = '{10'b1100000000, 8'h00, 1, FILT ? 12'h000 : 12'h8FC};
    tbl[21] = '{10'b1100000001, 8'hFC, 1, FILT ? 12'h000 : 12'h0FC};
    tbl[22] = '{10'b1100000000, 8'h00, 2, 12'h000};

    idle_inputs();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      {irq1_n, nmi_n, icf, ocf, tof, eici, eoci, etoi, sci, ack} = tbl[i].in;
      ackv = tbl[i].ackv;
      repeat (tbl[i].ticks) tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // NMI edge coincident with the acknowledge that clears the latch
    idle_inputs();
    do_reset();
    repeat (4) tick();
    nmi_n = 1'b0;
    repeat (LAT - 1) tick();
    check("nmi_early", 12'h000);
    tick();
    check("nmi_lat", 12'h8FC);
    nmi_n = 1'b1;
    repeat (3) tick();
    check("nmi_held", 12'h8FC);
    nmi_n = 1'b0;
    repeat (LAT - 1) tick();
    ack = 1'b1;
    ackv = 8'hFC;
    tick();
    check("coinc_svc", 12'h0FC);
    ack = 1'b0;
    tick();
    check("coinc_idle", 12'h000);
    tick();
    check("coinc_rearm", 12'h8FC);

    // clkren low freezes everything, including the synchronisers
    idle_inputs();
    do_reset();
    repeat (4) tick();
    irq1_n = 1'b0;
    clkren = 1'b0;
    repeat (10) begin
      tick();
      check("hold_off", 12'h000);
    end
    clkren = 1'b1;
    repeat (2) tick();
    check("resume_early", 12'h000);
    tick();
    check("resume", 12'h4F8);
    ack = 1'b1;
    ackv = 8'hF4;
    tick();
    check("bad_ack", 12'h4F8);
    ack = 1'b0;

    // asynchronous reset mid-HOLD, then NMI_n held low across reset release
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_hold", 12'h000);
    nmi_n = 1'b0;
    irq1_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) tick();
    check("nmi_low_rst", 12'h000);

    // randomized run against the model
    idle_inputs();
    do_reset();
    repeat (800) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(0, 7) == 0) irq1_n = ~irq1_n;
      {icf, ocf, tof, eici, eoci, etoi} = 6'($urandom);
      sci = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) == 0);
      ackv = $urandom_range(0, 1) ? m_vec : MV[$urandom_range(0, 5)];
      clkren = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
